redmule_z_buffer: RTL and testbench

- Output-side buffer between the RedMulE engine result path and the streamer's Z stream sink.
- Accepts one result row per handshake from the engine (N_ELEM x ELEM_W) into a small FIFO.
- Masks unused columns of partial tiles through data zeroing and byte strobes, and pads each row to the DW-wide stream beat.
- Counts rows and tiles, and signals completion only once the final row has left towards memory.

---
 rtl/redmule_pkg.sv | 30 +++
 rtl/redmule_z_fifo.sv | 57 +++++
 rtl/redmule_z_buffer.sv | 137 +++++++++++++
 tb/tb_redmule_z_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// Shared constants, types and the strobe helper for the RedMulE Z output buffer.
package redmule_pkg;

    localparam int unsigned Z_ELEM_W    = 16;
    localparam int unsigned Z_N_ELEM    = 16;
    localparam int unsigned Z_DW        = 288;
    localparam int unsigned Z_BUF_DEPTH = 4;
    localparam int unsigned Z_TCNT_W    = 16;
    localparam int unsigned Z_COLS_W    = $clog2(Z_N_ELEM) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} z_buf_state_e;

    typedef struct packed {
        logic [Z_TCNT_W-1:0] n_tiles;
        logic [Z_COLS_W-1:0] cols_valid;
    } z_buf_cfg_t;

    // One strobe group per valid element; padding bytes above the row stay 0.
    function automatic logic [Z_DW/8-1:0] z_strb_from_cols(input logic [Z_COLS_W-1:0] cols);
        logic [Z_DW/8-1:0] strb;
        strb = '0;
        for (int unsigned k = 0; k < Z_N_ELEM; k++) begin
            if (k < 32'(cols)) begin
                strb[k*(Z_ELEM_W/8) +: Z_ELEM_W/8] = '1;
            end
        end
        return strb;
    endfunction

endpackage

// File: rtl/redmule_z_fifo.sv
// Small power-of-two FIFO with occupancy count; async reset, synchronous clear.
module redmule_z_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Gate the head so the output reads as zero while nothing is buffered.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/redmule_z_buffer.sv
// Z output buffer: masks partial-tile columns, queues rows towards the stream
// sink and reports job completion once the final row has been handed off.
module redmule_z_buffer
    import redmule_pkg::*;
#(
    parameter int unsigned ELEM_W = Z_ELEM_W,
    parameter int unsigned N_ELEM = Z_N_ELEM,
    parameter int unsigned DW     = Z_DW,
    parameter int unsigned DEPTH  = Z_BUF_DEPTH,
    parameter int unsigned TCNT_W = Z_TCNT_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [TCNT_W-1:0]          n_tiles_i,
    input  logic [$clog2(N_ELEM):0]    cols_valid_i,
    input  logic                       eng_valid_i,
    output logic                       eng_ready_o,
    input  logic [N_ELEM*ELEM_W-1:0]   eng_data_i,
    input  logic                       eng_last_i,
    output logic                       z_valid_o,
    input  logic                       z_ready_i,
    output logic [DW-1:0]              z_data_o,
    output logic [DW/8-1:0]            z_strb_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [TCNT_W-1:0]          tiles_done_o
);

    localparam int unsigned COLS_W  = $clog2(N_ELEM) + 1;
    localparam int unsigned ENTRY_W = DW + DW/8 + 1;

    z_buf_state_e          state_q, state_d;
    z_buf_cfg_t            cfg_q, cfg_d;
    logic [TCNT_W-1:0]     tiles_in_q, tiles_in_d;
    logic [TCNT_W-1:0]     tiles_done_q, tiles_done_d;
    logic [COLS_W-1:0]     cols_norm;
    logic                  push, pop, pop_last;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [DW-1:0]         row_masked;
    logic [DW/8-1:0]       row_strb;
    logic [ENTRY_W-1:0]    wr_entry, rd_entry;

    assign cols_norm = (cols_valid_i == '0 || cols_valid_i > COLS_W'(N_ELEM)) ?
                       COLS_W'(N_ELEM) : cols_valid_i;

    assign eng_ready_o = (state_q == RUN) && !fifo_full;
    assign push        = eng_valid_i && eng_ready_o;
    assign z_valid_o   = !fifo_empty;
    assign pop         = z_valid_o && z_ready_i;

    always_comb begin
        row_masked = '0;
        for (int unsigned k = 0; k < N_ELEM; k++) begin
            if (k < 32'(cfg_q.cols_valid)) begin
                row_masked[k*ELEM_W +: ELEM_W] = eng_data_i[k*ELEM_W +: ELEM_W];
            end
        end
    end

    assign row_strb = z_strb_from_cols(cfg_q.cols_valid);
    assign wr_entry = {eng_last_i, row_strb, row_masked};

    redmule_z_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign z_data_o = rd_entry[DW-1:0];
    assign z_strb_o = rd_entry[DW +: DW/8];
    assign pop_last = rd_entry[ENTRY_W-1];

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        tiles_in_d   = tiles_in_q;
        tiles_done_d = tiles_done_q;
        if (push && eng_last_i) tiles_in_d = tiles_in_q + 1'b1;
        if (pop && pop_last)    tiles_done_d = tiles_done_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start_i && n_tiles_i != '0) begin
                    state_d          = RUN;
                    cfg_d.n_tiles    = n_tiles_i;
                    cfg_d.cols_valid = cols_norm;
                    tiles_in_d       = '0;
                    tiles_done_d     = '0;
                end
            end
            RUN: begin
                if (push && eng_last_i && tiles_in_d == cfg_q.n_tiles) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_count == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            tiles_in_q   <= '0;
            tiles_done_q <= '0;
        end else if (clear_i) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            tiles_in_q   <= '0;
            tiles_done_q <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            tiles_in_q   <= tiles_in_d;
            tiles_done_q <= tiles_done_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign tiles_done_o = tiles_done_q;

endmodule

// File: tb/tb_redmule_z_buffer.sv
// Directed-sequence bench with random row data checked against a queue model.
module tb_redmule_z_buffer;

    logic         clk = 1'b0;
    logic         rst, clear, start;
    logic [15:0]  n_tiles;
    logic [4:0]   cols;
    logic         eng_valid, eng_ready, eng_last;
    logic [255:0] eng_data;
    logic         z_valid, z_ready;
    logic [287:0] z_data;
    logic [35:0]  z_strb;
    logic         busy, done;
    logic [15:0]  tiles_done;

    typedef struct {
        logic [287:0] data;
        logic [35:0]  strb;
        logic         last;
    } beat_t;

    beat_t mq[$];
    int checks = 0, errors = 0, done_cnt = 0, exp_tiles = 0, job_cols = 16;

    always #5 clk = ~clk;

    redmule_z_buffer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .start_i      (start),
        .n_tiles_i    (n_tiles),
        .cols_valid_i (cols),
        .eng_valid_i  (eng_valid),
        .eng_ready_o  (eng_ready),
        .eng_data_i   (eng_data),
        .eng_last_i   (eng_last),
        .z_valid_o    (z_valid),
        .z_ready_i    (z_ready),
        .z_data_o     (z_data),
        .z_strb_o     (z_strb),
        .busy_o       (busy),
        .done_o       (done),
        .tiles_done_o (tiles_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int norm_cols(input int c);
        return (c == 0 || c > 16) ? 16 : c;
    endfunction

    function automatic logic [287:0] exp_data(input logic [255:0] d, input int c);
        logic [287:0] mask;
        mask = (288'(1) << (c * 16)) - 288'(1);
        return {32'b0, d} & mask;
    endfunction

    function automatic logic [35:0] exp_strb(input int c);
        return (36'(1) << (c * 2)) - 36'(1);
    endfunction

    function automatic logic [255:0] rand_row();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: starts and ends at posedge+1, model updated from the handshakes.
    task automatic step();
        beat_t b;
        check("z_valid", 288'(z_valid), 288'(mq.size() != 0));
        if (z_valid && z_ready && mq.size() != 0) begin
            check("z_data", z_data, mq[0].data);
            check("z_strb", 288'(z_strb), 288'(mq[0].strb));
            if (mq[0].last) exp_tiles++;
            mq.delete(0);
        end
        if (eng_valid && eng_ready) begin
            b.data = exp_data(eng_data, job_cols);
            b.strb = exp_strb(job_cols);
            b.last = eng_last;
            mq.push_back(b);
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        check("tiles_done", 288'(tiles_done), 288'(exp_tiles));
    endtask

    task automatic start_job(input int n, input int c);
        start   = 1'b1;
        n_tiles = 16'(n);
        cols    = 5'(c);
        if (n != 0) begin
            exp_tiles = 0;
            job_cols  = norm_cols(c);
        end
        step();
        start = 1'b0;
    endtask

    task automatic push_row(input logic [255:0] d, input logic last);
        logic acc;
        eng_valid = 1'b1;
        eng_data  = d;
        eng_last  = last;
        for (int i = 0; i < 50; i++) begin
            acc = eng_ready;
            step();
            if (acc) return;
        end
        checks++;
        errors++;
        $error("FAIL push_timeout: observed not accepted expected accepted within 50 cycles");
    endtask

    task automatic drain_and_finish(input int n);
        int empty_idx, done_idx, base;
        empty_idx = -1;
        done_idx  = -1;
        base      = done_cnt;
        eng_valid = 1'b0;
        z_ready   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (empty_idx < 0 && !z_valid) empty_idx = i;
            if (done_idx < 0 && done) begin
                done_idx = i;
                check("done_tiles", 288'(tiles_done), 288'(n));
            end
            step();
        end
        check("done_count", 288'(done_cnt - base), 288'(1));
        check("done_timing", 288'(done_idx), 288'(empty_idx + 1));
        check("tiles_done_end", 288'(tiles_done), 288'(n));
        check("busy_end", 288'(busy), 288'(0));
    endtask

    initial begin
        int base;
        rst = 1'b1; clear = 1'b0; start = 1'b0; n_tiles = '0; cols = '0;
        eng_valid = 1'b0; eng_data = '0; eng_last = 1'b0; z_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_eng_ready", 288'(eng_ready), 288'(0));
        check("rst_z_valid", 288'(z_valid), 288'(0));
        check("rst_done", 288'(done), 288'(0));
        check("rst_busy", 288'(busy), 288'(0));
        check("rst_tiles_done", 288'(tiles_done), 288'(0));
        check("rst_z_data", z_data, 288'(0));
        check("rst_z_strb", 288'(z_strb), 288'(0));
        rst = 1'b0;
        step();

        // Basic job: one tile, full width, sink always ready.
        start_job(1, 16);
        check("basic_busy", 288'(busy), 288'(1));
        z_ready = 1'b1;
        push_row(rand_row(), 1'b0);
        check("basic_strb_lit", 288'(z_strb), 288'(36'h0_FFFF_FFFF));
        check("basic_pad_zero", 288'(z_data[287:256]), 288'(0));
        push_row(rand_row(), 1'b0);
        push_row(rand_row(), 1'b1);
        drain_and_finish(1);

        // Partial tile: five columns of all-ones data.
        start_job(1, 5);
        z_ready = 1'b0;
        push_row({256{1'b1}}, 1'b1);
        check("partial_data", z_data, {208'b0, {80{1'b1}}});
        check("partial_strb", 288'(z_strb), 288'(36'h3FF));
        drain_and_finish(1);

        // Backpressure: sink stalled while five rows are offered.
        start_job(1, 16);
        z_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_row(rand_row(), 1'b0);
        eng_valid = 1'b1;
        eng_data  = rand_row();
        eng_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 288'(eng_ready), 288'(0));
            check("stall_data", z_data, mq[0].data);
            step();
        end
        z_ready = 1'b1;
        push_row(eng_data, 1'b1);
        drain_and_finish(1);

        // Steady push+pop at occupancy 2; cols=0 must behave as full width.
        start_job(1, 0);
        z_ready = 1'b0;
        push_row(rand_row(), 1'b0);
        push_row(rand_row(), 1'b0);
        z_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("steady_ready", 288'(eng_ready), 288'(1));
            check("steady_valid", 288'(z_valid), 288'(1));
            push_row(rand_row(), (i == 9));
        end
        drain_and_finish(1);

        // Multi-tile: three tiles of two rows; engine keeps offering in DRAIN.
        start_job(3, 16);
        z_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) z_ready = 1'b0;
            push_row(rand_row(), (i % 2 == 1));
        end
        eng_valid = 1'b1;
        eng_data  = rand_row();
        eng_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_ready", 288'(eng_ready), 288'(0));
            check("drain_busy", 288'(busy), 288'(1));
            step();
        end
        drain_and_finish(3);

        // Asynchronous reset with rows buffered.
        start_job(1, 16);
        z_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_row(rand_row(), 1'b0);
        eng_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_z_valid", 288'(z_valid), 288'(0));
        check("arst_busy", 288'(busy), 288'(0));
        check("arst_done", 288'(done), 288'(0));
        check("arst_eng_ready", 288'(eng_ready), 288'(0));
        mq.delete();
        exp_tiles = 0;
        base = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step();
        check("arst_no_done", 288'(done_cnt - base), 288'(0));

        // Synchronous clear with rows buffered.
        start_job(1, 16);
        for (int i = 0; i < 3; i++) push_row(rand_row(), 1'b0);
        eng_valid = 1'b0;
        clear = 1'b1;
        base = done_cnt;
        step();
        mq.delete();
        clear = 1'b0;
        check("clr_z_valid", 288'(z_valid), 288'(0));
        check("clr_busy", 288'(busy), 288'(0));
        repeat (4) step();
        check("clr_no_done", 288'(done_cnt - base), 288'(0));

        // Zero-tile start is ignored.
        start_job(0, 16);
        check("zero_tiles_busy", 288'(busy), 288'(0));
        step();
        check("zero_tiles_busy2", 288'(busy), 288'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
